// File: rtl/nlz_norm_seq_if.sv
// Handshake bundle for nlz_norm_seq: req/ack operand input, valid/ready result output.
interface nlz_norm_seq_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned EXP_W = 8
);
   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   logic             I_Clear;
   logic             I_Req;
   logic [WIDTH-1:0] I_Data;
   logic [EXP_W-1:0] I_Exp;
   logic             O_Ack;
   logic             O_Valid;
   logic             I_Ready;
   logic [WIDTH-1:0] O_Data;
   logic [CNT_W-1:0] O_Num;
   logic [EXP_W-1:0] O_Exp;
   logic             O_Zero;
   logic             O_Uflow;

   modport master (
      output I_Clear, I_Req, I_Data, I_Exp, I_Ready,
      input  O_Ack, O_Valid, O_Data, O_Num, O_Exp, O_Zero, O_Uflow
   );

   modport slave (
      input  I_Clear, I_Req, I_Data, I_Exp, I_Ready,
      output O_Ack, O_Valid, O_Data, O_Num, O_Exp, O_Zero, O_Uflow
   );
endinterface

// File: rtl/nlz_norm_seq.sv
// Multi-cycle mantissa normalizer: one shared 8-bit leading-zero stage scans byte lanes
// MSB-first, then shifts the operand left and lowers the exponent by the zero count.
module nlz_norm_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned EXP_W = 8
)(
   input  logic          clock,
   input  logic          reset,
   nlz_norm_seq_if.slave bus
);
   localparam int unsigned NUM_LANES = WIDTH / 8;
   localparam int unsigned CNT_W     = $clog2(WIDTH) + 1;
   localparam int unsigned LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int unsigned CMP_W     = EXP_W + CNT_W;

   typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

   state_t            r_state;
   logic [WIDTH-1:0]  r_opnd;
   logic [EXP_W-1:0]  r_exp;
   logic [LANE_W-1:0] r_lane;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_valid;
   logic [WIDTH-1:0]  r_odata;
   logic [CNT_W-1:0]  r_num;
   logic [EXP_W-1:0]  r_oexp;
   logic              r_zero;
   logic              r_uflow;

   logic [WIDTH-1:0]  w_lane_shift;
   logic [7:0]        w_byte;
   logic [3:0]        w_nlz8;
   logic [CNT_W-1:0]  w_cnt;
   logic              w_last;
   logic              w_uflow;

   // Bring lane k to the top so the byte select is a constant slice.
   assign w_lane_shift = r_opnd << {r_lane, 3'b000};
   assign w_byte       = w_lane_shift[WIDTH-1 -: 8];
   assign w_last       = (r_lane == LANE_W'(NUM_LANES - 1));

   always_comb begin
      w_nlz8 = 4'd8;
      for (int unsigned i = 0; i < 8; i++) begin
         if (w_byte[i]) w_nlz8 = 4'(7 - i);
      end
   end

   assign w_cnt   = CNT_W'({r_lane, 3'b000}) + CNT_W'(w_nlz8);
   assign w_uflow = CMP_W'(r_cnt) > CMP_W'(r_exp);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_opnd  <= '0;
         r_exp   <= '0;
         r_lane  <= '0;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_odata <= '0;
         r_num   <= '0;
         r_oexp  <= '0;
         r_zero  <= 1'b0;
         r_uflow <= 1'b0;
      end else if (bus.I_Clear) begin
         // Abort keeps the previous result registers; only the handshake is dropped.
         r_state <= IDLE;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.I_Req) begin
                  r_opnd  <= bus.I_Data;
                  r_exp   <= bus.I_Exp;
                  r_lane  <= '0;
                  r_state <= SCAN;
               end
            end
            SCAN: begin
               if (w_byte != '0) begin
                  r_cnt   <= w_cnt;
                  r_state <= SHIFT;
               end else if (!w_last) begin
                  r_lane <= r_lane + LANE_W'(1);
               end else begin
                  r_odata <= '0;
                  r_num   <= CNT_W'(WIDTH);
                  r_oexp  <= r_exp;
                  r_zero  <= 1'b1;
                  r_uflow <= 1'b0;
                  r_valid <= 1'b1;
                  r_state <= DONE;
               end
            end
            SHIFT: begin
               r_odata <= r_opnd << r_cnt;
               r_num   <= r_cnt;
               r_zero  <= 1'b0;
               if (w_uflow) begin
                  r_oexp  <= '0;
                  r_uflow <= 1'b1;
               end else begin
                  r_oexp  <= r_exp - EXP_W'(r_cnt);
                  r_uflow <= 1'b0;
               end
               r_valid <= 1'b1;
               r_state <= DONE;
            end
            DONE: begin
               if (bus.I_Ready) begin
                  r_valid <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.O_Ack   = (r_state == IDLE);
   assign bus.O_Valid = r_valid;
   assign bus.O_Data  = r_odata;
   assign bus.O_Num   = r_num;
   assign bus.O_Exp   = r_oexp;
   assign bus.O_Zero  = r_zero;
   assign bus.O_Uflow = r_uflow;
endmodule

// File: tb/tb_nlz_norm_seq.sv
// Directed, table-driven bench for nlz_norm_seq (WIDTH=32, EXP_W=8) plus handshake corner cases.
module tb_nlz_norm_seq;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   nlz_norm_seq_if #(.WIDTH(32), .EXP_W(8)) bus ();

   nlz_norm_seq #(.WIDTH(32), .EXP_W(8)) u_dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [7:0]  exp;
      int          lat;
      logic [31:0] q_data;
      logic [5:0]  q_num;
      logic [7:0]  q_exp;
      logic        q_zero;
      logic        q_uflow;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Presents one request in IDLE; returns #1 after the accepting edge.
   task automatic start(input logic [31:0] d, input logic [7:0] e);
      @(negedge clk);
      chk("ack_before_req", 64'(bus.O_Ack), 64'd1);
      bus.I_Data = d;
      bus.I_Exp  = e;
      bus.I_Req  = 1'b1;
      @(posedge clk);
      #1 bus.I_Req = 1'b0;
   endtask

   // Counts cycles from acceptance (cycle T+1 = 1) until O_Valid, bounded.
   task automatic wait_valid(output int c);
      c = 1;
      while (bus.O_Valid !== 1'b1 && c < 20) begin
         @(posedge clk);
         #1 c++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      total = 0;
      bad   = 0;
      vecs[0] = '{32'h8000_0000,  8'd10, 3, 32'h8000_0000,  6'd0,   8'd10, 1'b0, 1'b0};
      vecs[1] = '{32'h0000_0001,  8'd40, 6, 32'h8000_0000,  6'd31,  8'd9,  1'b0, 1'b0};
      vecs[2] = '{32'h0000_0000,  8'd7,  5, 32'h0000_0000,  6'd32,  8'd7,  1'b1, 1'b0};
      vecs[3] = '{32'h0001_0000,  8'd5,  4, 32'h8000_0000,  6'd15,  8'd0,  1'b0, 1'b1};
      vecs[4] = '{32'h00F0_0000,  8'd20, 4, 32'hF000_0000,  6'd8,   8'd12, 1'b0, 1'b0};
      vecs[5] = '{32'h0000_00FF,  8'd24, 6, 32'hFF00_0000,  6'd24,  8'd0,  1'b0, 1'b0};
      vecs[6] = '{32'h1234_5678,  8'd3,  3, 32'h91A2_B3C0,  6'd3,   8'd0,  1'b0, 1'b0};
      vecs[7] = '{32'h0000_4000,  8'd200,5, 32'h8000_0000,  6'd17,  8'd183,1'b0, 1'b0};
      vecs[8] = '{32'hFFFF_FFFF,  8'd0,  3, 32'hFFFF_FFFF,  6'd0,   8'd0,  1'b0, 1'b0};

      rst         = 1'b1;
      bus.I_Clear = 1'b0;
      bus.I_Req   = 1'b0;
      bus.I_Data  = '0;
      bus.I_Exp   = '0;
      bus.I_Ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 64'(bus.O_Valid), 64'd0);
      chk("rst_data",  64'(bus.O_Data),  64'd0);
      chk("rst_num",   64'(bus.O_Num),   64'd0);
      chk("rst_exp",   64'(bus.O_Exp),   64'd0);
      chk("rst_zero",  64'(bus.O_Zero),  64'd0);
      chk("rst_uflow", 64'(bus.O_Uflow), 64'd0);
      chk("rst_ack",   64'(bus.O_Ack),   64'd1);
      @(negedge clk) rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         start(vecs[i].data, vecs[i].exp);
         wait_valid(c);
         chk($sformatf("v%0d_latency", i), 64'(c), 64'(vecs[i].lat));
         chk($sformatf("v%0d_data", i),  64'(bus.O_Data),  64'(vecs[i].q_data));
         chk($sformatf("v%0d_num", i),   64'(bus.O_Num),   64'(vecs[i].q_num));
         chk($sformatf("v%0d_exp", i),   64'(bus.O_Exp),   64'(vecs[i].q_exp));
         chk($sformatf("v%0d_zero", i),  64'(bus.O_Zero),  64'(vecs[i].q_zero));
         chk($sformatf("v%0d_uflow", i), 64'(bus.O_Uflow), 64'(vecs[i].q_uflow));
         chk($sformatf("v%0d_ack_done", i), 64'(bus.O_Ack), 64'd0);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_valid_drop", i), 64'(bus.O_Valid), 64'd0);
         chk($sformatf("v%0d_ack_back", i),   64'(bus.O_Ack),   64'd1);
      end

      // Backpressure: result held for three cycles, stray request ignored.
      @(negedge clk) bus.I_Ready = 1'b0;
      start(32'h00F0_0000, 8'd20);
      wait_valid(c);
      chk("bp_latency", 64'(c), 64'd4);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("bp%0d_valid", i), 64'(bus.O_Valid), 64'd1);
         chk($sformatf("bp%0d_data", i),  64'(bus.O_Data),  64'hF000_0000);
         chk($sformatf("bp%0d_num", i),   64'(bus.O_Num),   64'd8);
         chk($sformatf("bp%0d_exp", i),   64'(bus.O_Exp),   64'd12);
         chk($sformatf("bp%0d_ack", i),   64'(bus.O_Ack),   64'd0);
         @(negedge clk);
         if (i == 0) begin
            bus.I_Req  = 1'b1;
            bus.I_Data = 32'hFFFF_FFFF;
            bus.I_Exp  = 8'd0;
         end
         @(posedge clk);
         #1 bus.I_Req = 1'b0;
      end
      chk("bp_hold_data", 64'(bus.O_Data), 64'hF000_0000);
      @(negedge clk) bus.I_Ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_valid", 64'(bus.O_Valid), 64'd0);
      chk("bp_release_ack",   64'(bus.O_Ack),   64'd1);
      @(posedge clk);
      #1;
      chk("bp_still_idle", 64'(bus.O_Ack), 64'd1);

      // Abort in cycle T+2: back to IDLE at T+3, no result ever emitted.
      start(32'h0000_00FF, 8'd8);
      @(posedge clk);
      @(negedge clk) bus.I_Clear = 1'b1;
      @(posedge clk);
      #1;
      bus.I_Clear = 1'b0;
      chk("clr_ack",   64'(bus.O_Ack),   64'd1);
      chk("clr_valid", 64'(bus.O_Valid), 64'd0);
      c = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1 if (bus.O_Valid === 1'b1) c++;
      end
      chk("clr_no_valid", 64'(c), 64'd0);
      chk("clr_keep_data", 64'(bus.O_Data), 64'hF000_0000);
      chk("clr_keep_num",  64'(bus.O_Num),  64'd8);

      // Asynchronous reset mid-SCAN, then a normal request.
      start(32'h0000_0001, 8'd40);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 64'(bus.O_Valid), 64'd0);
      chk("arst_data",  64'(bus.O_Data),  64'd0);
      chk("arst_num",   64'(bus.O_Num),   64'd0);
      chk("arst_exp",   64'(bus.O_Exp),   64'd0);
      chk("arst_ack",   64'(bus.O_Ack),   64'd1);
      @(negedge clk) rst = 1'b0;
      start(vecs[3].data, vecs[3].exp);
      wait_valid(c);
      chk("post_rst_latency", 64'(c), 64'(vecs[3].lat));
      chk("post_rst_data",  64'(bus.O_Data),  64'(vecs[3].q_data));
      chk("post_rst_num",   64'(bus.O_Num),   64'(vecs[3].q_num));
      chk("post_rst_exp",   64'(bus.O_Exp),   64'(vecs[3].q_exp));
      chk("post_rst_uflow", 64'(bus.O_Uflow), 64'(vecs[3].q_uflow));
      @(posedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
